// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: EX/MEM memory control word, access sizes, LSU states.
// No logic; types and constants only.
// Not applicable (no handshakes).
package riscv_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_size_t;

  // Store funct3 encodings coincide with the signed load encodings.
  localparam mem_size_t SB = LB;
  localparam mem_size_t SH = LH;
  localparam mem_size_t SW = LW;

  typedef struct packed {
    logic      MemRead;
    logic      MemWrite;
    mem_size_t MemSize;
  } MEM_ctrl;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables/replication, misalign detect, load extract/extend.
// Latency: purely combinational.
// Backpressure: none.
module lsu_align
  import riscv_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata[7:0];
    half_sel  = off[1] ? rdata[31:16] : rdata[15:0];
    be        = 4'b1111;
    wdata_rep = wdata;
    misalign  = 1'b0;
    load_data = rdata;

    case (off)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase

    // size[2] marks the unsigned load variants; size[1:0] is the access width.
    case (size[1:0])
      2'b00: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        load_data = size[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        be        = 4'b0011 << {off[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        misalign  = off[0];
        load_data = size[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        misalign = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Memory-stage load/store unit driving a req/gnt/rvalid data bus.
// Latency: load >= 3 stall cycles, store >= 2, misaligned 1; result shown in DONE.
// Backpressure: holds req and bus fields until gnt, stalls the pipeline until DONE.
module lsu
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  MEM_ctrl     MEMctrl_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall_out,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [3:0]  dmem_be_out,
  output logic [31:0] dmem_wdata_out,
  input  logic        dmem_gnt_in,
  input  logic        dmem_rvalid_in,
  input  logic [31:0] dmem_rdata_in,
  output logic [31:0] MEMdata_MEM_out,
  output logic        load_valid_out,
  output logic        misalign_err_out
);

  lsu_state_t  state;
  mem_size_t   size_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        misalign_q;
  logic [31:0] result_q;

  logic        op_vld;
  logic        is_store;
  mem_size_t   al_size;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_misalign;
  logic [31:0] al_load_data;

  assign op_vld   = MEMctrl_in.MemRead | MEMctrl_in.MemWrite;
  // Read+write together is illegal and degrades to a load.
  assign is_store = MEMctrl_in.MemWrite & ~MEMctrl_in.MemRead;

  // One aligner serves both directions: live inputs in IDLE, captured op afterwards.
  assign al_size = (state == IDLE) ? MEMctrl_in.MemSize : size_q;
  assign al_off  = (state == IDLE) ? addr_in[1:0] : off_q;

  lsu_align u_align (
    .size      (al_size),
    .off       (al_off),
    .wdata     (wdata_in),
    .rdata     (dmem_rdata_in),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .misalign  (al_misalign),
    .load_data (al_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      size_q     <= LB;
      off_q      <= 2'b00;
      addr_q     <= 32'b0;
      be_q       <= 4'b0;
      wdata_q    <= 32'b0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
      result_q   <= 32'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_vld) begin
            size_q     <= MEMctrl_in.MemSize;
            off_q      <= addr_in[1:0];
            addr_q     <= {addr_in[31:2], 2'b00};
            be_q       <= al_be;
            wdata_q    <= al_wdata;
            we_q       <= is_store;
            misalign_q <= al_misalign;
            if (al_misalign) begin
              result_q <= 32'b0;
              state    <= DONE;
            end else begin
              state    <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_gnt_in) begin
            state <= we_q ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (dmem_rvalid_in) begin
            result_q <= al_load_data;
            state    <= DONE;
          end
        end
        DONE: begin
          // The op still on the inputs is the one just finished; the pipeline advances now.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_out        = ((state == IDLE) & op_vld) | (state == REQ) | (state == WAIT);
  assign dmem_req_out     = (state == REQ);
  assign dmem_we_out      = we_q;
  assign dmem_addr_out    = addr_q;
  assign dmem_be_out      = be_q;
  assign dmem_wdata_out   = wdata_q;
  assign MEMdata_MEM_out  = result_q;
  assign load_valid_out   = (state == DONE) & ~we_q & ~misalign_q;
  assign misalign_err_out = (state == DONE) & misalign_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed ops push expected bus/result events, a monitor checks them.
// Stimulus also plays the data-memory side (grant delay, one-cycle rvalid).
module tb_lsu;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  MEM_ctrl     mem_ctrl;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        req;
  logic        we;
  logic [31:0] bus_addr;
  logic [3:0]  be;
  logic [31:0] bus_wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] mem_data;
  logic        load_valid;
  logic        misalign_err;

  lsu dut (
    .clk              (clk),
    .rst              (rst),
    .MEMctrl_in       (mem_ctrl),
    .addr_in          (addr),
    .wdata_in         (wdata),
    .stall_out        (stall),
    .dmem_req_out     (req),
    .dmem_we_out      (we),
    .dmem_addr_out    (bus_addr),
    .dmem_be_out      (be),
    .dmem_wdata_out   (bus_wdata),
    .dmem_gnt_in      (gnt),
    .dmem_rvalid_in   (rvalid),
    .dmem_rdata_in    (rdata),
    .MEMdata_MEM_out  (mem_data),
    .load_valid_out   (load_valid),
    .misalign_err_out (misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } req_exp_t;

  typedef struct {
    logic        mis;
    logic [31:0] data;
  } done_exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rword;
    int          gwait;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
    logic        e_mis;
    int          e_stall;
    int          e_reqs;
    logic        chain;
  } vec_t;

  req_exp_t  exp_req[$];
  done_exp_t exp_done[$];
  vec_t      vecs[$];

  int checks = 0;
  int errors = 0;
  int lv_seen = 0;
  int lv_expected = 0;
  logic [31:0] last_ld = 32'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the head of the expectation queues.
  initial begin
    forever begin
      @(negedge clk);
      if (req) begin
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr %h with no request expected", bus_addr);
        end else begin
          chk("req_addr", bus_addr, exp_req[0].addr);
          chk("req_be", {28'b0, be}, {28'b0, exp_req[0].be});
          chk("req_wdata", bus_wdata, exp_req[0].wdata);
          chk("req_we", {31'b0, we}, {31'b0, exp_req[0].we});
          if (gnt) void'(exp_req.pop_front());
        end
      end
      if (load_valid) lv_seen++;
      if (load_valid || misalign_err) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got lv %b mis %b with none expected", load_valid, misalign_err);
        end else begin
          chk("done_mis", {31'b0, misalign_err}, {31'b0, exp_done[0].mis});
          chk("done_lv", {31'b0, load_valid}, {31'b0, ~exp_done[0].mis});
          chk("done_data", mem_data, exp_done[0].data);
          void'(exp_done.pop_front());
        end
      end
    end
  end

  task automatic set_idle();
    mem_ctrl.MemRead  = 1'b0;
    mem_ctrl.MemWrite = 1'b0;
    mem_ctrl.MemSize  = LB;
    addr  = 32'b0;
    wdata = 32'b0;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_stall"}, {31'b0, stall}, 32'b0);
    chk({nm, "_req"}, {31'b0, req}, 32'b0);
    chk({nm, "_we"}, {31'b0, we}, 32'b0);
    chk({nm, "_addr"}, bus_addr, 32'b0);
    chk({nm, "_be"}, {28'b0, be}, 32'b0);
    chk({nm, "_wdata"}, bus_wdata, 32'b0);
    chk({nm, "_data"}, mem_data, 32'b0);
    chk({nm, "_lv"}, {31'b0, load_valid}, 32'b0);
    chk({nm, "_mis"}, {31'b0, misalign_err}, 32'b0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after DONE.
  task automatic run_op(input vec_t v);
    int   stalls = 0;
    int   reqs = 0;
    logic rv_pend = 1'b0;
    logic accepted;
    logic done = 1'b0;
    if (v.e_reqs > 0) exp_req.push_back('{v.e_addr, v.e_be, v.e_wdata, v.wr & ~v.rd});
    if (v.rd || v.e_mis) exp_done.push_back('{v.e_mis, v.e_data});
    if (v.rd && !v.e_mis) lv_expected++;
    mem_ctrl.MemRead  = v.rd;
    mem_ctrl.MemWrite = v.wr;
    mem_ctrl.MemSize  = mem_size_t'(v.sz);
    addr  = v.a;
    wdata = v.wd;
    for (int c = 0; c < 100 && !done; c++) begin
      gnt    = req && (reqs == v.gwait);
      rvalid = rv_pend;
      rdata  = rv_pend ? v.rword : 32'h5A5A_5A5A;
      @(negedge clk);
      accepted = req & gnt;
      if (req) reqs++;
      if (stall) stalls++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      rv_pend = accepted & v.rd;
    end
    gnt    = 1'b0;
    rvalid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL op_timeout: got no DONE at addr %h within 100 cycles", v.a);
    end
    chk("stall_cycles", stalls, v.e_stall);
    chk("req_cycles", reqs, v.e_reqs);
    if (v.rd || v.e_mis) last_ld = v.e_data;
  endtask

  initial begin
    // rd wr sz a wd rword gwait | e_addr e_be e_wdata e_data e_mis e_stall e_reqs chain
    vecs.push_back('{1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 3, 1, 0});
    vecs.push_back('{1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 0, 3, 1, 0});
    vecs.push_back('{1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 32'h100, 4'b1000, 32'h0, 32'h00000080, 0, 3, 1, 0});
    vecs.push_back('{1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 0, 32'h100, 4'b1100, 32'h0, 32'hFFFF80FF, 0, 3, 1, 0});
    vecs.push_back('{1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 0, 32'h100, 4'b1100, 32'h0, 32'h000080FF, 0, 3, 1, 0});
    vecs.push_back('{1, 0, 3'b000, 32'h102, 32'h0, 32'h80FF0000, 2, 32'h100, 4'b0100, 32'h0, 32'hFFFFFFFF, 0, 5, 3, 0});
    vecs.push_back('{0, 1, 3'b000, 32'h201, 32'hAB, 32'h0, 3, 32'h200, 4'b0010, 32'hABABABAB, 32'h0, 0, 5, 4, 0});
    vecs.push_back('{0, 1, 3'b001, 32'h202, 32'h1234, 32'h0, 0, 32'h200, 4'b1100, 32'h12341234, 32'h0, 0, 2, 1, 0});
    vecs.push_back('{0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 0, 32'h204, 4'b1111, 32'hCAFEF00D, 32'h0, 0, 2, 1, 0});
    vecs.push_back('{1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 1, 1, 0, 0});
    vecs.push_back('{0, 1, 3'b001, 32'h001, 32'h55, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 1, 1, 0, 0});
    vecs.push_back('{1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 1, 1, 0, 0});
    vecs.push_back('{1, 1, 3'b010, 32'h108, 32'h77777777, 32'h12345678, 0, 32'h108, 4'b1111, 32'h77777777, 32'h12345678, 0, 3, 1, 0});
    vecs.push_back('{1, 0, 3'b010, 32'h400, 32'h0, 32'h11111111, 0, 32'h400, 4'b1111, 32'h0, 32'h11111111, 0, 3, 1, 1});
    vecs.push_back('{1, 0, 3'b010, 32'h404, 32'h0, 32'h22222222, 0, 32'h404, 4'b1111, 32'h0, 32'h22222222, 0, 3, 1, 0});

    rst    = 1'b1;
    gnt    = 1'b0;
    rvalid = 1'b0;
    rdata  = 32'b0;
    set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_op(vecs[i]);
      if (!vecs[i].chain) begin
        set_idle();
        @(negedge clk);
        chk("idle_stall", {31'b0, stall}, 32'b0);
        if (!vecs[i].rd && !vecs[i].e_mis) chk("data_hold", mem_data, last_ld);
        @(posedge clk);
        #1;
      end
    end

    // Reset while waiting for rvalid, then a stale rvalid.
    exp_req.push_back('{32'h300, 4'b1111, 32'h0, 1'b0});
    mem_ctrl.MemRead  = 1'b1;
    mem_ctrl.MemWrite = 1'b0;
    mem_ctrl.MemSize  = LW;
    addr = 32'h300;
    @(posedge clk);
    #1;
    gnt = 1'b1;
    @(posedge clk);
    #1;
    gnt = 1'b0;
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    chk("wait_stall", {31'b0, stall}, 32'b1);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'h99999999;
    @(negedge clk);
    check_all_zero("rst_mid");
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    @(negedge clk);
    chk("stale_rv_lv", {31'b0, load_valid}, 32'b0);
    chk("stale_rv_data", mem_data, 32'b0);
    chk("stale_rv_stall", {31'b0, stall}, 32'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lv_count", lv_seen, lv_expected);
    chk("req_q_empty", exp_req.size(), 0);
    chk("done_q_empty", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1);
  end

endmodule
